// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix column scan, whole-frame debounce, one-hot key report.
// Define KEYPAD_RELEASE_EN to also strobe an all-zero code when a key is released.
module keypad_scanner #(
   parameter int SCAN_CNT     = 1000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  key_row,
   output logic [3:0]  key_col,
   output logic [15:0] scan_data,
   output logic        valid,
   output logic        multi_key
);

   localparam int CW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
   localparam int SW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CNT - 1);
   localparam logic [SW-1:0] STB_MAX  = SW'(DEBOUNCE_CNT);

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_col;
   logic [15:0]   r_frame;
   logic [15:0]   r_frame_cur;
   logic [15:0]   r_frame_prev;
   logic [15:0]   r_accept;
   logic [15:0]   r_data;
   logic [SW-1:0] r_stable;
   logic          r_rdy;
   logic          r_valid;
   logic          r_multi;

   logic          w_last;
   logic          w_same;
   logic [SW-1:0] w_stable_nxt;
   logic          w_take;
   logic          w_zero;
   logic          w_onehot;
`ifdef KEYPAD_RELEASE_EN
   logic          w_prev_onehot;
`endif

   assign w_last    = (r_cnt == CNT_LAST);
   assign key_col   = 4'b0001 << r_col;
   assign scan_data = r_data;
   assign valid     = r_valid;
   assign multi_key = r_multi;

   // Column dwell and frame capture; r_rdy marks the edge after a full frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_col       <= 2'd0;
         r_frame     <= '0;
         r_frame_cur <= '0;
         r_rdy       <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         if (w_last) begin
            r_cnt                     <= '0;
            r_col                     <= r_col + 2'd1;
            r_frame[{r_col, 2'b00} +: 4] <= key_row;
            if (r_col == 2'd3) begin
               r_frame_cur <= {key_row, r_frame[11:0]};
               r_rdy       <= 1'b1;
            end
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      w_same = (r_frame_cur == r_frame_prev);
      if (!w_same) begin
         w_stable_nxt = SW'(1);
      end else if (r_stable == STB_MAX) begin
         w_stable_nxt = r_stable;
      end else begin
         w_stable_nxt = r_stable + SW'(1);
      end
      w_take   = r_rdy && (w_stable_nxt == STB_MAX) &&
                 (r_frame_cur != r_accept);
      w_zero   = (r_frame_cur == 16'h0000);
      w_onehot = !w_zero &&
                 ((r_frame_cur & (r_frame_cur - 16'd1)) == 16'h0000);
`ifdef KEYPAD_RELEASE_EN
      w_prev_onehot = (r_accept != 16'h0000) &&
                      ((r_accept & (r_accept - 16'd1)) == 16'h0000);
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frame_prev <= '0;
         r_stable     <= '0;
         r_accept     <= '0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_multi      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (r_rdy) begin
            r_frame_prev <= r_frame_cur;
            r_stable     <= w_stable_nxt;
         end
         if (w_take) begin
            r_accept <= r_frame_cur;
            if (w_onehot) begin
               r_data  <= r_frame_cur;
               r_valid <= 1'b1;
               r_multi <= 1'b0;
            end else if (w_zero) begin
               r_multi <= 1'b0;
`ifdef KEYPAD_RELEASE_EN
               if (w_prev_onehot) begin
                  r_data  <= 16'h0000;
                  r_valid <= 1'b1;
               end
`endif
            end else begin
               r_multi <= 1'b1;
            end
         end
      end
   end

endmodule
